tt_um_jleugeri_ttt_scheduler: RTL and testbench

Sequencer for the TTT event network. On each `go_in` it snapshots every processor's start/stop event flags and visits each processor with a net event. For each such source it reads the source's target range from the connection table. It then streams one signed token update per target to the token demultiplexer under a valid/ready handshake, and holds the processors' global `enable_out` low until the whole sweep has finished.

---
 rtl/tt_um_jleugeri_ttt_pkg.sv | 20 ++
 rtl/tt_um_jleugeri_ttt_prio_enc.sv | 23 ++
 rtl/tt_um_jleugeri_ttt_scheduler.sv | 149 ++++++++++++++
 tb/tb_tt_um_jleugeri_ttt_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_um_jleugeri_ttt_pkg.sv
// Shared types and constants for the TTT event-network scheduler.
// Imported by the scheduler top and its priority encoder.
package tt_um_jleugeri_ttt_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_FETCH,
    S_DELIVER,
    S_DONE
  } state_t;

  localparam logic SIGN_GOOD = 1'b0;
  localparam logic SIGN_BAD  = 1'b1;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tt_um_jleugeri_ttt_prio_enc.sv
// Lowest-set-bit encoder used to pick the next pending source.
// Purely combinational; idx is 0 when no bit is set.
module tt_um_jleugeri_ttt_prio_enc #(
  parameter int N = 10,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tt_um_jleugeri_ttt_scheduler.sv
// Sweep sequencer: snapshots start/stop events, walks each net source
// and streams one signed token update per target over valid/ready.
module tt_um_jleugeri_ttt_scheduler
  import tt_um_jleugeri_ttt_pkg::*;
#(
  parameter int NUM_PROCESSORS = 10,
  parameter int IDX_BITS       = idx_width(NUM_PROCESSORS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        go_in,
  input  logic [2*NUM_PROCESSORS-1:0] tstartstop_in,
  output logic                        busy_out,
  output logic                        done_out,
  output logic                        enable_out,
  output logic                        cfg_rd_out,
  output logic [IDX_BITS-1:0]         cfg_addr_out,
  input  logic [IDX_BITS-1:0]         cfg_first_in,
  input  logic [IDX_BITS-1:0]         cfg_last_in,
  output logic                        tgt_valid_out,
  input  logic                        tgt_ready_in,
  output logic [IDX_BITS-1:0]         tgt_idx_out,
  output logic [IDX_BITS-1:0]         tgt_src_out,
  output logic                        tgt_sign_out
);

  localparam logic [IDX_BITS:0] N_W =
    (IDX_BITS + 1)'(NUM_PROCESSORS);
  localparam logic [IDX_BITS-1:0] MAX_IDX =
    IDX_BITS'(NUM_PROCESSORS - 1);

  state_t state;

  logic [NUM_PROCESSORS-1:0] pend;
  logic [NUM_PROCESSORS-1:0] sgn;
  logic [NUM_PROCESSORS-1:0] pend_load;
  logic [NUM_PROCESSORS-1:0] sgn_load;
  logic [IDX_BITS-1:0]       src;
  logic [IDX_BITS-1:0]       last_r;
  logic [IDX_BITS-1:0]       enc_idx;
  logic                      enc_any;
  logic [IDX_BITS-1:0]       last_clamp;
  logic                      range_bad;

  // both flags set means the events cancel and the source is skipped
  always_comb begin
    pend_load = '0;
    sgn_load  = '0;
    for (int i = 0; i < NUM_PROCESSORS; i++) begin
      pend_load[i] = tstartstop_in[2*i] ^ tstartstop_in[2*i+1];
      sgn_load[i]  = tstartstop_in[2*i+1];
    end
  end

  always_comb begin
    last_clamp = (cfg_last_in > MAX_IDX) ? MAX_IDX : cfg_last_in;
    range_bad  = (cfg_first_in > last_clamp) ||
                 ({1'b0, cfg_first_in} >= N_W);
  end

  tt_um_jleugeri_ttt_prio_enc #(
    .N (NUM_PROCESSORS),
    .W (IDX_BITS)
  ) u_enc (
    .req (pend),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      pend          <= '0;
      sgn           <= '0;
      src           <= '0;
      last_r        <= '0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
      enable_out    <= 1'b1;
      cfg_rd_out    <= 1'b0;
      cfg_addr_out  <= '0;
      tgt_valid_out <= 1'b0;
      tgt_idx_out   <= '0;
      tgt_src_out   <= '0;
      tgt_sign_out  <= SIGN_GOOD;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (go_in) begin
            pend       <= pend_load;
            sgn        <= sgn_load;
            busy_out   <= 1'b1;
            enable_out <= 1'b0;
            state      <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (enc_any) begin
            src          <= enc_idx;
            cfg_rd_out   <= 1'b1;
            cfg_addr_out <= enc_idx;
            state        <= S_FETCH;
          end else begin
            done_out <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_FETCH: begin
          cfg_rd_out   <= 1'b0;
          cfg_addr_out <= '0;
          if (range_bad) begin
            pend[src] <= 1'b0;
            state     <= S_SCAN;
          end else begin
            last_r        <= last_clamp;
            tgt_valid_out <= 1'b1;
            tgt_idx_out   <= cfg_first_in;
            tgt_src_out   <= src;
            tgt_sign_out  <= sgn[src] ? SIGN_BAD : SIGN_GOOD;
            state         <= S_DELIVER;
          end
        end
        S_DELIVER: begin
          if (tgt_ready_in) begin
            // last_r <= N-1, so tgt stops before it could wrap
            if (tgt_idx_out == last_r) begin
              pend[src]     <= 1'b0;
              tgt_valid_out <= 1'b0;
              tgt_idx_out   <= '0;
              tgt_src_out   <= '0;
              tgt_sign_out  <= SIGN_GOOD;
              state         <= S_SCAN;
            end else begin
              tgt_idx_out <= tgt_idx_out + IDX_BITS'(1);
            end
          end
        end
        S_DONE: begin
          done_out   <= 1'b0;
          busy_out   <= 1'b0;
          enable_out <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_scheduler.sv
// Scoreboard bench for the TTT scheduler: a sweep-level model queues
// expected updates and done timing; a negedge monitor compares.
module tb_tt_um_jleugeri_ttt_scheduler;

  localparam int N = 10;
  localparam int W = 4;

  typedef struct {
    int tgt;
    int src;
    int sgn;
    int rel;
  } upd_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           go_in = 1'b0;
  logic [2*N-1:0] tstartstop_in = '0;
  logic           busy_out, done_out, enable_out;
  logic           cfg_rd_out;
  logic [W-1:0]   cfg_addr_out, cfg_first_in, cfg_last_in;
  logic           tgt_valid_out;
  logic           tgt_ready_in = 1'b1;
  logic [W-1:0]   tgt_idx_out, tgt_src_out;
  logic           tgt_sign_out;

  logic [W-1:0] tbl_first [16];
  logic [W-1:0] tbl_last  [16];

  assign cfg_first_in = tbl_first[cfg_addr_out];
  assign cfg_last_in  = tbl_last[cfg_addr_out];

  tt_um_jleugeri_ttt_scheduler #(
    .NUM_PROCESSORS (N),
    .IDX_BITS       (W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .go_in         (go_in),
    .tstartstop_in (tstartstop_in),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .enable_out    (enable_out),
    .cfg_rd_out    (cfg_rd_out),
    .cfg_addr_out  (cfg_addr_out),
    .cfg_first_in  (cfg_first_in),
    .cfg_last_in   (cfg_last_in),
    .tgt_valid_out (tgt_valid_out),
    .tgt_ready_in  (tgt_ready_in),
    .tgt_idx_out   (tgt_idx_out),
    .tgt_src_out   (tgt_src_out),
    .tgt_sign_out  (tgt_sign_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   failures = 0;
  upd_t exp_q [$];
  int   done_q [$];
  int   go_cyc = 0;
  int   stalls = 0;
  int   done_cnt = 0;
  int   hold = 0;
  bit   rnd_ready = 1'b0;

  task automatic check_eq(input string name, input int act,
                          input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // Reference: sources in ascending order, one update per clamped
  // target; each source costs FETCH + targets + SCAN cycles.
  task automatic push_model(input logic [2*N-1:0] f);
    int pre;
    int fi;
    int la;
    int cnt;
    bit st;
    bit sp;
    upd_t e;
    pre = 0;
    for (int i = 0; i < N; i++) begin
      st = f[2*i];
      sp = f[2*i+1];
      if (st ^ sp) begin
        fi  = int'(tbl_first[i]);
        la  = int'(tbl_last[i]);
        if (la > N - 1) la = N - 1;
        cnt = 0;
        for (int t = fi; t <= la; t++) begin
          e.tgt = t;
          e.src = i;
          e.sgn = int'(sp);
          e.rel = 3 + pre + cnt;
          exp_q.push_back(e);
          cnt++;
        end
        pre += 2 + cnt;
      end
    end
    done_q.push_back(2 + pre);
  endtask

  always @(posedge clk) begin
    #3;
    if (hold > 0 && tgt_valid_out) begin
      tgt_ready_in = 1'b0;
      hold--;
    end else if (rnd_ready) begin
      tgt_ready_in = 1'($urandom_range(0, 1));
    end else begin
      tgt_ready_in = 1'b1;
    end
  end

  bit         prev_stall = 1'b0;
  bit         prev_done = 1'b0;
  logic [W:0] p_idx, p_src;
  logic       p_sign;
  upd_t       m_e;
  int         m_d;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (tgt_valid_out && tgt_ready_in) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_update", int'(tgt_idx_out), -1);
        end else begin
          m_e = exp_q.pop_front();
          check_eq("upd_tgt", int'(tgt_idx_out), m_e.tgt);
          check_eq("upd_src", int'(tgt_src_out), m_e.src);
          check_eq("upd_sign", int'(tgt_sign_out), m_e.sgn);
          check_eq("upd_cycle", cyc - go_cyc, m_e.rel + stalls);
        end
      end
      if (prev_stall) begin
        check_eq("hold_valid", int'(tgt_valid_out), 1);
        check_eq("hold_idx", int'(tgt_idx_out), int'(p_idx));
        check_eq("hold_src", int'(tgt_src_out), int'(p_src));
        check_eq("hold_sign", int'(tgt_sign_out), int'(p_sign));
      end
      if (!tgt_valid_out)
        check_eq("idle_tgt_zero",
                 int'({tgt_idx_out, tgt_src_out, tgt_sign_out}), 0);
      if (!cfg_rd_out)
        check_eq("idle_cfg_addr_zero", int'(cfg_addr_out), 0);
      check_eq("enable_vs_busy", int'(enable_out), int'(!busy_out));
      if (done_out) begin
        done_cnt++;
        if (done_q.size() == 0) begin
          check_eq("unexpected_done", 1, 0);
        end else begin
          m_d = done_q.pop_front();
          check_eq("done_cycle", cyc - go_cyc, m_d + stalls);
          check_eq("missing_updates", exp_q.size(), 0);
        end
      end
      if (prev_done) begin
        check_eq("done_one_cycle", int'(done_out), 0);
        check_eq("enable_after_done", int'(enable_out), 1);
      end
      prev_stall = tgt_valid_out && !tgt_ready_in;
      prev_done  = done_out;
      p_idx      = {1'b0, tgt_idx_out};
      p_src      = {1'b0, tgt_src_out};
      p_sign     = tgt_sign_out;
      if (tgt_valid_out && !tgt_ready_in) stalls++;
    end
  end

  task automatic slot();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy_out && t < 500) begin
      slot();
      t++;
    end
    if (t >= 500) check_eq("idle_timeout", 1, 0);
  endtask

  task automatic check_reset_vals();
    check_eq("rst_busy", int'(busy_out), 0);
    check_eq("rst_done", int'(done_out), 0);
    check_eq("rst_enable", int'(enable_out), 1);
    check_eq("rst_cfg_rd", int'(cfg_rd_out), 0);
    check_eq("rst_cfg_addr", int'(cfg_addr_out), 0);
    check_eq("rst_valid", int'(tgt_valid_out), 0);
    check_eq("rst_idx", int'(tgt_idx_out), 0);
    check_eq("rst_src", int'(tgt_src_out), 0);
    check_eq("rst_sign", int'(tgt_sign_out), 0);
  endtask

  task automatic start_go(input logic [2*N-1:0] flags, input int h);
    wait_idle();
    hold          = h;
    tstartstop_in = flags;
    push_model(flags);
    stalls        = 0;
    go_cyc        = cyc;
    go_in         = 1'b1;
    slot();
    go_in         = 1'b0;
    tstartstop_in = 20'($urandom);
  endtask

  task automatic run_sweep(input logic [2*N-1:0] flags, input int h,
                           input bit disturb);
    int dc;
    int t;
    dc = done_cnt;
    start_go(flags, h);
    if (disturb) begin
      slot();
      check_eq("busy_mid_sweep", int'(busy_out), 1);
      tstartstop_in = 20'($urandom);
      go_in = 1'b1;
      slot();
      go_in = 1'b0;
      tstartstop_in = ~tstartstop_in;
    end
    t = 0;
    while (done_cnt == dc && t < 3000) begin
      slot();
      t++;
    end
    if (t >= 3000) begin
      check_eq("sweep_timeout", 1, 0);
      exp_q.delete();
      done_q.delete();
    end
    slot();
    slot();
    if (disturb) check_eq("go_not_queued", int'(busy_out), 0);
  endtask

  task automatic rand_tables();
    for (int i = 0; i < 16; i++) begin
      tbl_first[i] = 4'($urandom);
      tbl_last[i]  = 4'($urandom);
    end
  endtask

  logic [2*N-1:0] fl;
  int             tw;

  initial begin
    rand_tables();
    repeat (3) slot();
    check_reset_vals();
    rst_n = 1'b1;
    slot();

    // two sources: start on 2 (4..5), stop on 7 (3..3)
    tbl_first[2] = 4'd4; tbl_last[2] = 4'd5;
    tbl_first[7] = 4'd3; tbl_last[7] = 4'd3;
    fl = '0; fl[4] = 1'b1; fl[15] = 1'b1;
    run_sweep(fl, 0, 1'b0);

    // cancelled processor 1, empty range on processor 4
    tbl_first[4] = 4'd6; tbl_last[4] = 4'd2;
    fl = '0; fl[2] = 1'b1; fl[3] = 1'b1; fl[8] = 1'b1;
    run_sweep(fl, 0, 1'b0);

    // empty sweep
    run_sweep('0, 0, 1'b0);

    // backpressure on the first update
    fl = '0; fl[4] = 1'b1; fl[15] = 1'b1;
    run_sweep(fl, 3, 1'b0);

    // clamp of last to N-1, and first beyond N
    tbl_first[3] = 4'd8;  tbl_last[3] = 4'd15;
    tbl_first[5] = 4'd12; tbl_last[5] = 4'd15;
    fl = '0; fl[6] = 1'b1; fl[11] = 1'b1;
    run_sweep(fl, 0, 1'b0);

    // snapshot and go-while-busy, then a fresh go
    tbl_first[0] = 4'd0; tbl_last[0] = 4'd9;
    fl = '0; fl[0] = 1'b1;
    run_sweep(fl, 0, 1'b1);
    fl = '0; fl[1] = 1'b1; fl[6] = 1'b1;
    run_sweep(fl, 0, 1'b0);

    // reset while stalled in DELIVER
    start_go(fl, 1000);
    tw = 0;
    while (!tgt_valid_out && tw < 50) begin
      slot();
      tw++;
    end
    check_eq("reach_deliver", int'(tgt_valid_out), 1);
    slot();
    slot();
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    exp_q.delete();
    done_q.delete();
    hold = 0;
    slot();
    rst_n = 1'b1;
    slot();
    fl = '0; fl[0] = 1'b1; fl[19] = 1'b1;
    run_sweep(fl, 0, 1'b0);

    // randomized sweeps with random ready
    rnd_ready = 1'b1;
    for (int k = 0; k < 25; k++) begin
      rand_tables();
      run_sweep(20'($urandom), 0, (k % 5) == 0);
    end
    rnd_ready = 1'b0;

    check_eq("leftover_updates", exp_q.size(), 0);
    check_eq("leftover_dones", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
